led_fade_driver: RTL and testbench

//   Downstream of the 2-bit LED PIO: consumes its out_port (one on/off bit per LED) and drives
//   the board LED pins. Each LED soft-fades between off and full on using a per-LED brightness

---
 rtl/led_fade_driver.sv | 118 +++++++++++
 tb/tb_led_fade_driver.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// LED fade driver: each LED soft-fades between off and full on using a per-LED
// brightness ramp and one shared PWM generator; fade_en=0 switches instantly.
module led_fade_driver #(
  parameter int NUM_LEDS   = 2,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 256,
  parameter int RAMP_DIV   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_ctrl,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]    PRE_ZERO  = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
  localparam logic [RDIV_W-1:0]   RDIV_LAST = RDIV_W'(RAMP_DIV - 1);
  localparam logic [RDIV_W-1:0]   RDIV_ZERO = {RDIV_W{1'b0}};
  localparam logic [RDIV_W-1:0]   RDIV_ONE  = RDIV_W'(1);
  localparam logic [PWM_BITS-1:0] MAXL      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ZERO_L    = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] ONE_L     = PWM_BITS'(1);

  logic [NUM_LEDS-1:0] ctrl_q_r;
  logic [PRE_W-1:0]    pre_cnt_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [RDIV_W-1:0]   rdiv_r;
  logic [PWM_BITS-1:0] level_r     [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt_s [NUM_LEDS];
  logic [PWM_BITS-1:0] target_s    [NUM_LEDS];
  logic [NUM_LEDS-1:0] lit_s;
  logic [NUM_LEDS-1:0] led_out_r;
  logic                busy_r;
  logic                busy_nxt_s;
  logic                tick_s;
  logic                period_end_s;
  logic                step_s;

  assign led_out = led_out_r;
  assign busy    = busy_r;

  // Timing strobes derived from the free-running counters.
  always_comb begin
    tick_s       = (pre_cnt_r == PRE_LAST);
    period_end_s = tick_s && (pwm_cnt_r == MAXL);
    step_s       = period_end_s && (rdiv_r == RDIV_LAST);
  end

  // Input registration, prescaler, PWM counter and ramp divider.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q_r  <= {NUM_LEDS{1'b0}};
      pre_cnt_r <= PRE_ZERO;
      pwm_cnt_r <= ZERO_L;
      rdiv_r    <= RDIV_ZERO;
    end else begin
      ctrl_q_r <= led_ctrl;
      if (tick_s) begin
        pre_cnt_r <= PRE_ZERO;
        pwm_cnt_r <= pwm_cnt_r + ONE_L;
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_ONE;
      end
      if (period_end_s) begin
        rdiv_r <= (rdiv_r == RDIV_LAST) ? RDIV_ZERO : (rdiv_r + RDIV_ONE);
      end
    end
  end

  // Per-LED target, saturating level update and PWM lit decode.
  // busy looks at the level being loaded, so an instant switch never flags busy.
  always_comb begin
    busy_nxt_s = 1'b0;
    lit_s      = {NUM_LEDS{1'b0}};
    for (int i = 0; i < NUM_LEDS; i++) begin
      target_s[i] = ctrl_q_r[i] ? MAXL : ZERO_L;
      if (!fade_en) begin
        level_nxt_s[i] = target_s[i];
      end else if (step_s && ctrl_q_r[i] && (level_r[i] != MAXL)) begin
        level_nxt_s[i] = level_r[i] + ONE_L;
      end else if (step_s && !ctrl_q_r[i] && (level_r[i] != ZERO_L)) begin
        level_nxt_s[i] = level_r[i] - ONE_L;
      end else begin
        level_nxt_s[i] = level_r[i];
      end
      if (level_r[i] == MAXL) begin
        lit_s[i] = 1'b1;
      end else begin
        lit_s[i] = (pwm_cnt_r < level_r[i]);
      end
      busy_nxt_s = busy_nxt_s | (level_nxt_s[i] != target_s[i]);
    end
  end

  // Brightness levels and registered pin drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        level_r[i] <= ZERO_L;
      end
      led_out_r <= {NUM_LEDS{ACTIVE_LOW}};
      busy_r    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        level_r[i] <= level_nxt_s[i];
      end
      led_out_r <= lit_s ^ {NUM_LEDS{ACTIVE_LOW}};
      busy_r    <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with PWM_BITS=4, PRESCALE=2, RAMP_DIV=1:
// one PWM period and one brightness step every 32 clk.
module tb_led_fade_driver;

  logic       clk;
  logic       reset;
  logic [1:0] led_ctrl;
  logic       fade_en;
  logic [1:0] led_out;
  logic       busy;
  logic [1:0] led_ctrl_hi;
  logic       fade_en_hi;
  logic [1:0] led_out_hi;
  logic       busy_hi;

  int vectors;
  int miscompares;

  led_fade_driver #(
    .NUM_LEDS(2), .PWM_BITS(4), .PRESCALE(2), .RAMP_DIV(1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .led_ctrl(led_ctrl), .fade_en(fade_en),
    .led_out(led_out), .busy(busy)
  );

  led_fade_driver #(
    .NUM_LEDS(2), .PWM_BITS(4), .PRESCALE(2), .RAMP_DIV(1), .ACTIVE_LOW(1'b0)
  ) dut_hi (
    .clk(clk), .reset(reset), .led_ctrl(led_ctrl_hi), .fade_en(fade_en_hi),
    .led_out(led_out_hi), .busy(busy_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two edges and releases it on a falling edge, so the next
  // negedge samples the state after edge 1 of freshly reset counters.
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    led_ctrl = 2'b11;
    fade_en  = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (led_out !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_dark: got %b expected %b", led_out, 2'b11);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected %b", busy, 1'b0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (led_out !== ((k < 3) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL release_latency k=%0d: got %b expected %b", k, led_out,
                 (k < 3) ? 2'b11 : 2'b00);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL release_busy k=%0d: got %b expected %b", k, busy, 1'b0);
      end
    end
  endtask

  task automatic test_instant_switch();
    fade_en  = 1'b0;
    led_ctrl = 2'b00;
    apply_reset();
    repeat (5) @(negedge clk);
    led_ctrl = 2'b01;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      vectors++;
      if (led_out !== ((j >= 3) ? 2'b10 : 2'b11)) begin
        miscompares++;
        $display("FAIL instant_switch t+%0d: got %b expected %b", j, led_out,
                 (j >= 3) ? 2'b10 : 2'b11);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL instant_busy t+%0d: got %b expected %b", j, busy, 1'b0);
      end
    end
  endtask

  // Level m holds for states 32m..32m+31, seen on led_out one clk later:
  // lit count in window m is 2*m, 32 once at full brightness.
  task automatic test_fade_up();
    int lit_cnt;
    int exp_cnt;
    int m;
    fade_en  = 1'b1;
    led_ctrl = 2'b01;
    apply_reset();
    lit_cnt = 0;
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      if (led_out[0] == 1'b0) lit_cnt++;
      if (k % 32 == 0) begin
        m       = k / 32 - 1;
        exp_cnt = (m >= 15) ? 32 : 2 * m;
        vectors++;
        if (lit_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL fade_up_duty window=%0d: got %0d expected %0d", m, lit_cnt, exp_cnt);
        end
        vectors++;
        if (led_out[1] !== 1'b1) begin
          miscompares++;
          $display("FAIL fade_up_led1 window=%0d: got %b expected %b", m, led_out[1], 1'b1);
        end
        lit_cnt = 0;
      end
      if (k == 200) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL fade_up_busy_mid: got %b expected %b", busy, 1'b1);
        end
      end
      if (k == 481 || k == 520) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL fade_up_busy_done k=%0d: got %b expected %b", k, busy, 1'b0);
        end
      end
      if (k > 512) begin
        vectors++;
        if (led_out[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL fade_up_full k=%0d: got %b expected %b", k, led_out[0], 1'b0);
        end
      end
    end
  endtask

  task automatic test_reversal();
    int lit_cnt;
    int exp_cnt;
    int m;
    fade_en  = 1'b1;
    led_ctrl = 2'b01;
    apply_reset();
    lit_cnt = 0;
    for (int k = 1; k <= 576; k++) begin
      @(negedge clk);
      if (led_out[0] == 1'b0) lit_cnt++;
      if (k % 32 == 0) begin
        m       = k / 32 - 1;
        exp_cnt = (m < 8) ? 2 * m : ((m <= 16) ? 2 * (16 - m) : 0);
        vectors++;
        if (lit_cnt !== exp_cnt) begin
          miscompares++;
          $display("FAIL reversal_duty window=%0d: got %0d expected %0d", m, lit_cnt, exp_cnt);
        end
        lit_cnt = 0;
      end
      if (k == 256) led_ctrl = 2'b00;
      if (k == 400) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL reversal_busy_mid: got %b expected %b", busy, 1'b1);
        end
      end
      if (k == 576) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL reversal_busy_done: got %b expected %b", busy, 1'b0);
        end
        vectors++;
        if (led_out !== 2'b11) begin
          miscompares++;
          $display("FAIL reversal_floor: got %b expected %b", led_out, 2'b11);
        end
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int lit_cnt;
    fade_en  = 1'b1;
    led_ctrl = 2'b01;
    apply_reset();
    repeat (300) @(negedge clk);
    vectors++;
    if (led_out[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_ramp_lit: got %b expected %b", led_out[0], 1'b0);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (led_out !== 2'b11) begin
      miscompares++;
      $display("FAIL async_reset_dark: got %b expected %b", led_out, 2'b11);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_busy: got %b expected %b", busy, 1'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    lit_cnt = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k <= 32) begin
        vectors++;
        if (led_out !== 2'b11) begin
          miscompares++;
          $display("FAIL restart_dark k=%0d: got %b expected %b", k, led_out, 2'b11);
        end
      end else if (led_out[0] == 1'b0) begin
        lit_cnt++;
      end
    end
    vectors++;
    if (lit_cnt !== 2) begin
      miscompares++;
      $display("FAIL restart_level1_duty: got %0d expected %0d", lit_cnt, 2);
    end
  endtask

  task automatic test_active_high();
    int lit_cnt;
    int exp_cnt;
    int m;
    fade_en_hi  = 1'b0;
    led_ctrl_hi = 2'b10;
    apply_reset();
    lit_cnt = 0;
    for (int k = 1; k <= 544; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        vectors++;
        if (led_out_hi !== ((k < 3) ? 2'b00 : 2'b10)) begin
          miscompares++;
          $display("FAIL active_high_latency k=%0d: got %b expected %b", k, led_out_hi,
                   (k < 3) ? 2'b00 : 2'b10);
        end
      end
      if (led_out_hi[1] == 1'b1) lit_cnt++;
      if (k % 32 == 0) begin
        m = k / 32 - 1;
        if (m >= 1) begin
          exp_cnt = (m == 1) ? 32 : 2 * (16 - m);
          vectors++;
          if (lit_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL active_high_ramp window=%0d: got %0d expected %0d", m, lit_cnt, exp_cnt);
          end
          vectors++;
          if (led_out_hi[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL active_high_led0 window=%0d: got %b expected %b", m, led_out_hi[0], 1'b0);
          end
        end
        lit_cnt = 0;
      end
      if (k == 40) begin
        led_ctrl_hi = 2'b00;
        fade_en_hi  = 1'b1;
      end
      if (k == 100) begin
        vectors++;
        if (busy_hi !== 1'b1) begin
          miscompares++;
          $display("FAIL active_high_busy_mid: got %b expected %b", busy_hi, 1'b1);
        end
      end
      if (k == 544) begin
        vectors++;
        if (busy_hi !== 1'b0) begin
          miscompares++;
          $display("FAIL active_high_busy_done: got %b expected %b", busy_hi, 1'b0);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    led_ctrl    = 2'b00;
    fade_en     = 1'b0;
    led_ctrl_hi = 2'b00;
    fade_en_hi  = 1'b0;
    test_reset();
    test_instant_switch();
    test_fade_up();
    test_reversal();
    test_reset_mid_ramp();
    test_active_high();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
